cache_ram_arb: RTL and testbench

CACHE_RAM_ARB -- requirements
Module: cache_ram_arb

---
 rtl/cache_ram_arb.sv | 115 +++++++++++
 tb/tb_cache_ram_arb.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ram_arb.sv
// Read/refill arbiter for a single-port cache line RAM.
// Define CACHE_INIT_SWEEP_EN to zero every entry after reset.
module cache_ram_arb #(
  parameter int INDEX_W = 6,
  parameter int LINE_W  = 128,
  parameter int ENTRIES = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rd_req,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_gnt,
  output logic               rd_rvalid,
  output logic [LINE_W-1:0]  rd_rdata,
  input  logic               wr_req,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [LINE_W-1:0]  wr_wdata,
  output logic               wr_gnt,
  output logic [INDEX_W-1:0] ram_index,
  output logic               ram_wen,
  output logic [LINE_W-1:0]  ram_wdata,
  input  logic [LINE_W-1:0]  ram_rdata,
  output logic               init_done
);

  if (ENTRIES != (1 << INDEX_W)) begin : g_bad_cfg
    $error("cache_ram_arb: ENTRIES must equal 2**INDEX_W");
  end

  logic               run;
  logic               sweep;
  logic [INDEX_W-1:0] sweep_index;
  logic               last_wr;
  logic [INDEX_W-1:0] last_index;

`ifdef CACHE_INIT_SWEEP_EN
  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [INDEX_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + INDEX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == INDEX_W'(ENTRIES - 1))
      state_nxt = RUN;
  end

  assign run         = (state == RUN);
  assign sweep       = (state == INIT);
  assign sweep_index = cnt;
`else
  assign run         = 1'b1;
  assign sweep       = 1'b0;
  assign sweep_index = '0;
`endif

  assign init_done = run;

  // last_wr=1 means the write side won the most recent grant
  always_comb begin
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    ram_wen   = 1'b0;
    ram_wdata = '0;
    ram_index = last_index;
    if (rstn) begin
      if (sweep) begin
        ram_wen   = 1'b1;
        ram_index = sweep_index;
      end else if (run) begin
        if (rd_req && (!wr_req || last_wr))
          rd_gnt = 1'b1;
        else if (wr_req)
          wr_gnt = 1'b1;
        if (rd_gnt) begin
          ram_index = rd_index;
        end
        if (wr_gnt) begin
          ram_index = wr_index;
          ram_wen   = 1'b1;
          ram_wdata = wr_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_wr    <= 1'b1;
      last_index <= '0;
      rd_rvalid  <= 1'b0;
      rd_rdata   <= '0;
    end else begin
      last_index <= ram_index;
      if (rd_gnt || wr_gnt) last_wr <= wr_gnt;
      rd_rvalid <= rd_gnt;
      if (rd_gnt) rd_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_cache_ram_arb.sv
// Bench for cache_ram_arb with a behavioural RAM and arbiter model.
// Works for builds with and without CACHE_INIT_SWEEP_EN.
module tb_cache_ram_arb;
  localparam int IW = 6;
  localparam int LW = 128;
  localparam int N  = 64;
`ifdef CACHE_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          rd_req;
  logic [IW-1:0] rd_index;
  logic          rd_gnt;
  logic          rd_rvalid;
  logic [LW-1:0] rd_rdata;
  logic          wr_req;
  logic [IW-1:0] wr_index;
  logic [LW-1:0] wr_wdata;
  logic          wr_gnt;
  logic [IW-1:0] ram_index;
  logic          ram_wen;
  logic [LW-1:0] ram_wdata;
  logic [LW-1:0] ram_rdata;
  logic          init_done;

  cache_ram_arb #(
    .INDEX_W(IW),
    .LINE_W (LW),
    .ENTRIES(N)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rd_req   (rd_req),
    .rd_index (rd_index),
    .rd_gnt   (rd_gnt),
    .rd_rvalid(rd_rvalid),
    .rd_rdata (rd_rdata),
    .wr_req   (wr_req),
    .wr_index (wr_index),
    .wr_wdata (wr_wdata),
    .wr_gnt   (wr_gnt),
    .ram_index(ram_index),
    .ram_wen  (ram_wen),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external line RAM, seeded with garbage so the sweep is visible
  logic [LW-1:0] ram [N];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < N; i++)
        ram[i] <= {4{32'hDEADBEEF}} ^ LW'(i + 1);
      seeded <= 1'b1;
    end else if (ram_wen) begin
      ram[ram_index] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_index];

  int nerr;
  int nchk;

  logic [LW-1:0] m_mem [N];
  bit            m_known [N];
  bit            m_last_wr;
  bit            m_rvalid;
  logic [LW-1:0] m_rdata;
  bit            m_rknown;
  logic [IW-1:0] m_last_idx;

  task automatic model_reset();
    m_last_wr  = 1'b1;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rknown   = 1'b1;
    m_last_idx = '0;
  endtask

  task automatic model_swept();
    for (int i = 0; i < N; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b1;
    end
    m_last_idx = IW'(N - 1);
  endtask

  task automatic arb(input bit r, input bit w,
                     output bit gr, output bit gw);
    if (r && w) begin
      gr = m_last_wr;
      gw = !m_last_wr;
    end else begin
      gr = r;
      gw = w;
    end
  endtask

  task automatic commit(input bit gr, input bit gw,
                        input logic [IW-1:0] ri,
                        input logic [IW-1:0] wi,
                        input logic [LW-1:0] wd);
    m_rvalid = gr;
    if (gr) begin
      m_rdata    = m_mem[ri];
      m_rknown   = m_known[ri];
      m_last_idx = ri;
      m_last_wr  = 1'b0;
    end
    if (gw) begin
      m_mem[wi]   = wd;
      m_known[wi] = 1'b1;
      m_last_idx  = wi;
      m_last_wr   = 1'b1;
    end
  endtask

  task automatic drive(input bit rr, input logic [IW-1:0] ri,
                       input bit wr, input logic [IW-1:0] wi,
                       input logic [LW-1:0] wd);
    @(negedge clk);
    rd_req   = rr;
    rd_index = ri;
    wr_req   = wr;
    wr_index = wi;
    wr_wdata = wd;
    #1;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd_req = 1'b1;
    wr_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if ({rd_gnt, wr_gnt} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_gnt got %b exp 00", {rd_gnt, wr_gnt});
    end
    nchk++;
    if (rd_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rvalid got %b exp 0", rd_rvalid);
    end
    nchk++;
    if (rd_rdata !== '0) begin
      nerr++;
      $display("FAIL reset_rdata got %h exp 0", rd_rdata);
    end
    nchk++;
    if (ram_index !== '0) begin
      nerr++;
      $display("FAIL reset_index got %0d exp 0", ram_index);
    end
    nchk++;
    if (init_done !== !SWEEP) begin
      nerr++;
      $display("FAIL reset_init_done got %b exp %b", init_done, !SWEEP);
    end
  endtask

  task automatic test_init();
    logic [LW-1:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    rstn = 1'b1;
    rd_req = 1'b1; rd_index = 3;
    wr_req = 1'b1; wr_index = 7; wr_wdata = w;
    #1;
    if (SWEEP) begin
      for (int i = 0; i < N; i++) begin
        nchk++;
        if ({ram_wen, ram_index, ram_wdata, rd_gnt, wr_gnt, init_done}
            !== {1'b1, IW'(i), {LW{1'b0}}, 3'b000}) begin
          nerr++;
          $display("FAIL sweep_%0d wen=%b idx=%0d gnt=%b%b done=%b exp idx %0d",
                   i, ram_wen, ram_index, rd_gnt, wr_gnt, init_done, i);
        end
        @(negedge clk);
        #1;
      end
      model_swept();
    end
    nchk++;
    if ({init_done, rd_gnt, wr_gnt, ram_index} !== {3'b110, IW'(3)}) begin
      nerr++;
      $display("FAIL first_grant done=%b gnt=%b%b idx=%0d exp 1 10 3",
               init_done, rd_gnt, wr_gnt, ram_index);
    end
    clk_edge();
    commit(1'b1, 1'b0, 3, 7, w);
    nchk++;
    if (rd_rvalid !== 1'b1 || (m_rknown && rd_rdata !== m_rdata)) begin
      nerr++;
      $display("FAIL first_read v=%b d=%h exp 1 %h", rd_rvalid, rd_rdata, m_rdata);
    end
    @(negedge clk);
    #1;
    nchk++;
    if ({rd_gnt, wr_gnt, ram_wen, ram_index} !== {3'b011, IW'(7)}
        || ram_wdata !== w) begin
      nerr++;
      $display("FAIL held_write gnt=%b%b wen=%b idx=%0d d=%h exp 01 1 7 %h",
               rd_gnt, wr_gnt, ram_wen, ram_index, ram_wdata, w);
    end
    clk_edge();
    commit(1'b0, 1'b1, 3, 7, w);
    nchk++;
    if (rd_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL rvalid_pulse got %b exp 0", rd_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [LW-1:0] d;
    bit exp_rd;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2, 1'b1, 2, d);
      exp_rd = (k % 2 == 0);
      nchk++;
      if ({rd_gnt, wr_gnt} !== {exp_rd, !exp_rd}) begin
        nerr++;
        $display("FAIL rr_%0d gnt=%b%b exp %b%b",
                 k, rd_gnt, wr_gnt, exp_rd, !exp_rd);
      end
      clk_edge();
      commit(exp_rd, !exp_rd, 2, 2, d);
      nchk++;
      if (rd_rvalid !== exp_rd || (exp_rd && m_rknown && rd_rdata !== m_rdata)) begin
        nerr++;
        $display("FAIL rr_data_%0d v=%b d=%h exp %b %h",
                 k, rd_rvalid, rd_rdata, exp_rd, m_rdata);
      end
    end
  endtask

  task automatic test_read_basic();
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    drive(1'b0, 0, 1'b1, 5, a5);
    nchk++;
    if ({rd_gnt, wr_gnt, ram_wen, ram_index} !== {3'b011, IW'(5)}
        || ram_wdata !== a5) begin
      nerr++;
      $display("FAIL wr5 gnt=%b%b wen=%b idx=%0d d=%h",
               rd_gnt, wr_gnt, ram_wen, ram_index, ram_wdata);
    end
    clk_edge();
    commit(1'b0, 1'b1, 0, 5, a5);
    drive(1'b1, 5, 1'b0, 0, '0);
    nchk++;
    if ({rd_gnt, wr_gnt, ram_wen, ram_index} !== {3'b100, IW'(5)}) begin
      nerr++;
      $display("FAIL rd5 gnt=%b%b wen=%b idx=%0d exp 10 0 5",
               rd_gnt, wr_gnt, ram_wen, ram_index);
    end
    clk_edge();
    commit(1'b1, 1'b0, 5, 0, '0);
    nchk++;
    if (rd_rvalid !== 1'b1 || rd_rdata !== a5) begin
      nerr++;
      $display("FAIL rd5_data v=%b d=%h exp 1 %h", rd_rvalid, rd_rdata, a5);
    end
    drive(1'b0, 0, 1'b0, 0, '1);
    nchk++;
    if ({rd_gnt, wr_gnt, ram_wen, ram_index} !== {3'b000, IW'(5)}
        || ram_wdata !== '0) begin
      nerr++;
      $display("FAIL idle gnt=%b%b wen=%b idx=%0d d=%h exp 00 0 5 0",
               rd_gnt, wr_gnt, ram_wen, ram_index, ram_wdata);
    end
    clk_edge();
    commit(1'b0, 1'b0, 0, 0, '0);
    nchk++;
    if (rd_rvalid !== 1'b0 || rd_rdata !== a5) begin
      nerr++;
      $display("FAIL hold_data v=%b d=%h exp 0 %h", rd_rvalid, rd_rdata, a5);
    end
  endtask

  task automatic test_fwd();
    logic [LW-1:0] v;
    v = LW'(16'h1234);
    drive(1'b0, 0, 1'b1, 9, v);
    clk_edge();
    commit(1'b0, 1'b1, 0, 9, v);
    drive(1'b1, 9, 1'b0, 0, '0);
    nchk++;
    if (rd_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL fwd_gnt got %b exp 1", rd_gnt);
    end
    clk_edge();
    commit(1'b1, 1'b0, 9, 0, '0);
    nchk++;
    if (rd_rvalid !== 1'b1 || rd_rdata !== v) begin
      nerr++;
      $display("FAIL fwd_data v=%b d=%h exp 1 %h", rd_rvalid, rd_rdata, v);
    end
  endtask

  task automatic test_random();
    bit p_rd, p_wr, gr, gw;
    logic [IW-1:0] ri, wi, ei;
    logic [LW-1:0] wd, ed;
    p_rd = 1'b0; p_wr = 1'b0;
    ri = 5; wi = 0; wd = '0;
    for (int c = 0; c < 300; c++) begin
      if (!p_rd && $urandom_range(0, 1) == 1) begin
        p_rd = 1'b1;
        ri = IW'($urandom_range(0, N - 1));
        if (!m_known[ri]) ri = 5;
      end
      if (!p_wr && $urandom_range(0, 2) == 0) begin
        p_wr = 1'b1;
        wi = IW'($urandom_range(0, N - 1));
        wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      drive(p_rd, ri, p_wr, wi, wd);
      arb(p_rd, p_wr, gr, gw);
      ei = gr ? ri : (gw ? wi : m_last_idx);
      ed = gw ? wd : '0;
      nchk++;
      if ({rd_gnt, wr_gnt, ram_wen, ram_index} !== {gr, gw, gw, ei}
          || ram_wdata !== ed) begin
        nerr++;
        $display("FAIL rand_arb_%0d gnt=%b%b wen=%b idx=%0d exp %b%b %b %0d",
                 c, rd_gnt, wr_gnt, ram_wen, ram_index, gr, gw, gw, ei);
      end
      clk_edge();
      commit(gr, gw, ri, wi, wd);
      if (gr) p_rd = 1'b0;
      if (gw) p_wr = 1'b0;
      nchk++;
      if (rd_rvalid !== m_rvalid || (m_rknown && rd_rdata !== m_rdata)) begin
        nerr++;
        $display("FAIL rand_rd_%0d v=%b d=%h exp %b %h",
                 c, rd_rvalid, rd_rdata, m_rvalid, m_rdata);
      end
    end
    drive(1'b0, 0, 1'b0, 0, '0);
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    drive(1'b1, 9, 1'b0, 0, '0);
    clk_edge();
    commit(1'b1, 1'b0, 9, 0, '0);
    #2;
    rstn = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    #1;
    model_reset();
    nchk++;
    if ({rd_rvalid, rd_gnt, wr_gnt, ram_index} !== {3'b000, IW'(0)}
        || rd_rdata !== '0) begin
      nerr++;
      $display("FAIL mid_reset v=%b gnt=%b%b idx=%0d d=%h exp 0 00 0 0",
               rd_rvalid, rd_gnt, wr_gnt, ram_index, rd_rdata);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    if (SWEEP) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        #1;
      end
      nchk++;
      if (ram_index !== IW'(30)) begin
        nerr++;
        $display("FAIL sweep_at30 got %0d exp 30", ram_index);
      end
      #1;
      rstn = 1'b0;
      #1;
      nchk++;
      if ({ram_index, init_done} !== {IW'(0), 1'b0}) begin
        nerr++;
        $display("FAIL sweep_abort idx=%0d done=%b exp 0 0", ram_index, init_done);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      for (int i = 0; i < N; i++) begin
        nchk++;
        if ({init_done, ram_index} !== {1'b0, IW'(i)}) begin
          nerr++;
          $display("FAIL resweep_%0d done=%b idx=%0d exp 0 %0d",
                   i, init_done, ram_index, i);
        end
        @(negedge clk);
        #1;
      end
      model_swept();
    end
    rd_req = 1'b1; rd_index = 4;
    wr_req = 1'b1; wr_index = 4; wr_wdata = d;
    #1;
    nchk++;
    if ({init_done, rd_gnt, wr_gnt} !== 3'b110) begin
      nerr++;
      $display("FAIL post_reset_tie done=%b gnt=%b%b exp 1 10",
               init_done, rd_gnt, wr_gnt);
    end
    clk_edge();
    commit(1'b1, 1'b0, 4, 4, d);
    drive(1'b0, 0, 1'b0, 0, '0);
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    for (int i = 0; i < N; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    model_reset();
    rstn     = 1'b0;
    rd_req   = 1'b0;
    rd_index = '0;
    wr_req   = 1'b0;
    wr_index = '0;
    wr_wdata = '0;
    test_reset();
    test_init();
    test_round_robin();
    test_read_basic();
    test_fwd();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
